// File: rtl/hamming_sched_pkg.sv
// Shared state encoding and width helpers for the Hamming chunk sequencer.
package hamming_sched_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Ceiling log2; returns 0 for v <= 1.
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(v)) r = i + 1;
    end
    return r;
  endfunction

  // Ceiling log2 with a floor of 1, for index ports that must stay at least one bit wide.
  function automatic int unsigned clog2_min1(input int unsigned v);
    return (clog2(v) == 0) ? 1 : clog2(v);
  endfunction

endpackage

// File: rtl/hamming_popcount.sv
// Combinational XOR + population count of one chunk pair.
module hamming_popcount
  import hamming_sched_pkg::*;
#(
  parameter  int unsigned CHUNK_W = 1000,
  localparam int unsigned PC_W    = clog2(CHUNK_W + 1)
) (
  input  logic [CHUNK_W-1:0] i_x,
  input  logic [CHUNK_W-1:0] i_y,
  output logic [PC_W-1:0]    o_count_c
);

  logic [CHUNK_W-1:0] w_diff;
  logic [PC_W-1:0]    w_sum;

  // Count differing bit positions between the two operands.
  always_comb begin
    w_diff = i_x ^ i_y;
    w_sum  = '0;
    for (int i = 0; i < int'(CHUNK_W); i++) begin
      w_sum = w_sum + PC_W'(w_diff[i]);
    end
  end

  assign o_count_c = w_sum;

endmodule

// File: rtl/hamming_chunk_sched.sv
// Job sequencer for the Hamming-distance accumulator: accepts NUM_CHUNKS chunk
// pairs, accumulates popcount(x^y) and hands the total to the result consumer.
module hamming_chunk_sched
  import hamming_sched_pkg::*;
#(
  parameter  int unsigned CHUNK_W    = 1000,
  parameter  int unsigned NUM_CHUNKS = 16,
  localparam int unsigned OUT_W      = clog2(CHUNK_W * NUM_CHUNKS + 1),
  localparam int unsigned PC_W       = clog2(CHUNK_W + 1),
  localparam int unsigned IDX_W      = clog2_min1(NUM_CHUNKS)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               abort,
  output logic               busy,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [CHUNK_W-1:0] x_chunk,
  input  logic [CHUNK_W-1:0] y_chunk,
  output logic [IDX_W-1:0]   chunk_idx,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [OUT_W-1:0]   result
);

  state_t             r_state;
  state_t             w_state_nxt;
  logic [OUT_W-1:0]   r_acc;
  logic [OUT_W-1:0]   w_acc_nxt;
  logic [IDX_W-1:0]   r_cnt;
  logic [IDX_W-1:0]   w_cnt_nxt;
  logic [OUT_W-1:0]   r_result;
  logic [OUT_W-1:0]   w_result_nxt;
  logic [PC_W-1:0]    w_pc;
  logic [OUT_W-1:0]   w_sum;
  logic               w_last;

  hamming_popcount #(
    .CHUNK_W (CHUNK_W)
  ) u_popcount (
    .i_x       (x_chunk),
    .i_y       (y_chunk),
    .o_count_c (w_pc)
  );

  assign w_sum  = r_acc + OUT_W'(w_pc);
  assign w_last = (r_cnt == IDX_W'(NUM_CHUNKS - 1));

  // State, accumulator, chunk counter and result registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= IDLE;
      r_acc    <= '0;
      r_cnt    <= '0;
      r_result <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_acc    <= w_acc_nxt;
      r_cnt    <= w_cnt_nxt;
      r_result <= w_result_nxt;
    end
  end

  // Next-state logic; abort outranks accept, out_ready and start.
  always_comb begin
    w_state_nxt  = r_state;
    w_acc_nxt    = r_acc;
    w_cnt_nxt    = r_cnt;
    w_result_nxt = r_result;
    case (r_state)
      IDLE: begin
        if (start && !abort) begin
          w_acc_nxt   = '0;
          w_cnt_nxt   = '0;
          w_state_nxt = RUN;
        end
      end
      RUN: begin
        if (abort) begin
          w_acc_nxt   = '0;
          w_cnt_nxt   = '0;
          w_state_nxt = IDLE;
        end else if (in_valid) begin
          w_acc_nxt = w_sum;
          if (w_last) begin
            w_result_nxt = w_sum;
            w_cnt_nxt    = '0;
            w_state_nxt  = DONE;
          end else begin
            w_cnt_nxt = r_cnt + IDX_W'(1);
          end
        end
      end
      DONE: begin
        if (abort) begin
          w_acc_nxt   = '0;
          w_cnt_nxt   = '0;
          w_state_nxt = IDLE;
        end else if (out_ready) begin
          if (start) begin
            w_acc_nxt   = '0;
            w_cnt_nxt   = '0;
            w_state_nxt = RUN;
          end else begin
            w_state_nxt = IDLE;
          end
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  assign in_ready  = (r_state == RUN);
  assign out_valid = (r_state == DONE);
  assign busy      = (r_state != IDLE);
  assign chunk_idx = r_cnt;
  assign result    = r_result;

endmodule
